// File: rtl/sfifo_prog.sv
`default_nettype none
// ============================================================================
//  Module   : sfifo_prog
//  Purpose  : Parametrised single-clock FIFO with fill-level output,
//             programmable almost-full / almost-empty thresholds and a
//             selectable read mode (registered or first-word-fall-through).
//             Optional sticky overflow / underflow error flags, compiled in
//             when the macro SFIFO_ERR_EN is defined.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     entries, power of 2, >= 4
//    WIDTH     data bits per entry
//    AF_LEVEL  o_almost_full  when count >= AF_LEVEL (1..DEPTH)
//    AE_LEVEL  o_almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//    FWFT      0 = registered read (1-cycle latency), 1 = fall-through
//  Ports
//    i_clk, i_rst_n        clock (rising edge), async active-low reset
//    i_wr_en, i_data_in    write request and data
//    i_rd_en               read request (pop/acknowledge when FWFT=1)
//    o_data_out, o_valid   read data and its qualifier
//    o_full, o_empty       count == DEPTH / count == 0
//    o_almost_full/empty   threshold flags
//    o_count               entries stored
//    i_err_clr             clears the sticky error flags
//    o_overflow            sticky: write attempted while full
//    o_underflow           sticky: read attempted while empty
//  Configuration macro
//    SFIFO_ERR_EN          defined   -> sticky error flags implemented
//                          undefined -> error outputs tied low, no flops
// ============================================================================
module sfifo_prog #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_data_in,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_data_out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_err_clr,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the address bits match.
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;

    localparam logic [c_ptr_w-1:0] c_af_level = c_ptr_w'(AF_LEVEL);
    localparam logic [c_ptr_w-1:0] c_ae_level = c_ptr_w'(AE_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0]   wr_ptr_q;
    logic [c_ptr_w-1:0]   wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q;
    logic [c_ptr_w-1:0]   rd_ptr_d;

    // Storage array; deliberately not reset so it maps onto RAM cells.
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic [c_addr_w-1:0]  w_wr_addr;
    logic [c_addr_w-1:0]  w_rd_addr;
    logic [c_ptr_w-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_accept;
    logic                 w_rd_accept;
    logic [WIDTH-1:0]     w_rd_word;

    // ------------------------------------------------------------------
    // Status decode: purely from registered pointers, never from inputs
    // ------------------------------------------------------------------
    assign w_wr_addr = wr_ptr_q[c_addr_w-1:0];
    assign w_rd_addr = rd_ptr_q[c_addr_w-1:0];

    // Modulo subtraction gives the fill level across pointer wrap.
    assign w_count   = wr_ptr_q - rd_ptr_q;
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[c_addr_w] != rd_ptr_q[c_addr_w]) &&
                       (w_wr_addr == w_rd_addr);

    assign o_count        = w_count;
    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_full  = (w_count >= c_af_level);
    assign o_almost_empty = (w_count <= c_ae_level);

    // A write into a full FIFO or a read from an empty one is dropped.
    // Simultaneous write+read on an empty FIFO therefore only writes (no
    // pass-through) and on a full FIFO only reads.
    assign w_wr_accept = i_wr_en & ~w_full;
    assign w_rd_accept = i_rd_en & ~w_empty;

    assign w_rd_word   = mem_q[w_rd_addr];

    // ------------------------------------------------------------------
    // Pointer update
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Array write is indexed directly rather than through a full-array
    // next-state copy, keeping the storage inferable as RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            mem_q[w_wr_addr] <= i_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented as soon as it is stored. Output is
            // forced to zero while empty so reset and idle never expose
            // uninitialised storage.
            assign o_data_out = w_empty ? '0 : w_rd_word;
            assign o_valid    = ~w_empty;
        end else begin : g_reg
            logic [WIDTH-1:0] data_out_q;
            logic [WIDTH-1:0] data_out_d;
            logic             valid_q;
            logic             valid_d;

            // Output register loads only on an accepted read and holds
            // otherwise; o_valid marks the single cycle of fresh data.
            always_comb begin
                data_out_d = data_out_q;
                valid_d    = w_rd_accept;
                if (w_rd_accept) begin
                    data_out_d = w_rd_word;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_out_q <= '0;
                    valid_q    <= 1'b0;
                end else begin
                    data_out_q <= data_out_d;
                    valid_q    <= valid_d;
                end
            end

            assign o_data_out = data_out_q;
            assign o_valid    = valid_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef SFIFO_ERR_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Clear is applied first so that a new error in the clear cycle wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (i_wr_en & w_full) begin
            overflow_d = 1'b1;
        end
        if (i_rd_en & w_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`else
    // Error tracking compiled out; the clear input has no function.
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign o_overflow       = 1'b0;
    assign o_underflow      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sfifo_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfifo_prog
//  Purpose  : Directed self-checking bench for sfifo_prog. Two instances
//             (registered read and fall-through) share every input, so
//             level/flag behaviour is checked on both and read-data timing
//             on each in its own mode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_prog;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_in;

    logic [7:0] dout_r,  dout_f;
    logic       valid_r, valid_f;
    logic       full_r,  full_f;
    logic       empty_r, empty_f;
    logic       af_r,    af_f;
    logic       ae_r,    ae_f;
    logic [4:0] count_r, count_f;
    logic       ovf_r,   ovf_f;
    logic       unf_r,   unf_f;

    int checks = 0;
    int errors = 0;

    sfifo_prog #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_reg (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_data_in(data_in),
        .i_rd_en(rd_en), .o_data_out(dout_r), .o_valid(valid_r),
        .o_full(full_r), .o_empty(empty_r), .o_almost_full(af_r),
        .o_almost_empty(ae_r), .o_count(count_r), .i_err_clr(err_clr),
        .o_overflow(ovf_r), .o_underflow(unf_r)
    );

    sfifo_prog #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_data_in(data_in),
        .i_rd_en(rd_en), .o_data_out(dout_f), .o_valid(valid_f),
        .o_full(full_f), .o_empty(empty_f), .o_almost_full(af_f),
        .o_almost_empty(ae_f), .o_count(count_f), .i_err_clr(err_clr),
        .o_overflow(ovf_f), .o_underflow(unf_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        tick(); tick();
        checks++; if (count_r !== 5'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count_r); end
        checks++; if (empty_r !== 1'b1 || ae_r !== 1'b1) begin errors++; $display("FAIL reset_empty got empty=%b ae=%b expected 1 1", empty_r, ae_r); end
        checks++; if (full_r !== 1'b0 || af_r !== 1'b0) begin errors++; $display("FAIL reset_full got full=%b af=%b expected 0 0", full_r, af_r); end
        checks++; if (dout_r !== 8'h00 || valid_r !== 1'b0) begin errors++; $display("FAIL reset_reg_out got %h/%b expected 00/0", dout_r, valid_r); end
        checks++; if (dout_f !== 8'h00 || valid_f !== 1'b0) begin errors++; $display("FAIL reset_fwft_out got %h/%b expected 00/0", dout_f, valid_f); end
        checks++; if (ovf_r !== 1'b0 || unf_r !== 1'b0) begin errors++; $display("FAIL reset_err got ovf=%b unf=%b expected 0 0", ovf_r, unf_r); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            tick();
            checks++; if (count_r !== 5'(i + 1) || count_f !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got %0d/%0d expected %0d", count_r, count_f, i + 1); end
            checks++; if (af_r !== (i + 1 >= 14) || ae_r !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_thresh at %0d got af=%b ae=%b", i + 1, af_r, ae_r); end
            checks++; if (full_r !== (i + 1 == 16) || empty_r !== 1'b0) begin errors++; $display("FAIL fill_full at %0d got full=%b empty=%b", i + 1, full_r, empty_r); end
        end
        wr_en = 1'b0;
        checks++; if (dout_f !== 8'h00 || valid_f !== 1'b1) begin errors++; $display("FAIL fill_fwft_head got %h/%b expected 00/1", dout_f, valid_f); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout_f !== 8'(i)) begin errors++; $display("FAIL drain_fwft got %h expected %h", dout_f, 8'(i)); end
            rd_en = 1'b1;
            tick();
            checks++; if (dout_r !== 8'(i) || valid_r !== 1'b1) begin errors++; $display("FAIL drain_reg got %h/%b expected %h/1", dout_r, valid_r, 8'(i)); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (count_r !== 5'd0 || empty_r !== 1'b1 || ae_r !== 1'b1) begin errors++; $display("FAIL drain_empty got count=%0d empty=%b ae=%b", count_r, empty_r, ae_r); end
        checks++; if (valid_r !== 1'b0 || valid_f !== 1'b0) begin errors++; $display("FAIL drain_valid got %b/%b expected 0/0", valid_r, valid_f); end
    endtask

    task automatic test_reg_read();
        wr_en = 1'b1; data_in = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++; if (valid_r !== 1'b0) begin errors++; $display("FAIL regrd_early_valid got %b expected 0", valid_r); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (dout_r !== 8'hA5 || valid_r !== 1'b1) begin errors++; $display("FAIL regrd_data got %h/%b expected a5/1", dout_r, valid_r); end
        tick();
        checks++; if (dout_r !== 8'hA5 || valid_r !== 1'b0) begin errors++; $display("FAIL regrd_hold got %h/%b expected a5/0", dout_r, valid_r); end
    endtask

    task automatic test_fwft();
        wr_en = 1'b1; data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks++; if (dout_f !== 8'h3C || valid_f !== 1'b1) begin errors++; $display("FAIL fwft_show got %h/%b expected 3c/1", dout_f, valid_f); end
        checks++; if (valid_r !== 1'b0 || count_f !== 5'd1) begin errors++; $display("FAIL fwft_side got valid_r=%b count=%0d expected 0 1", valid_r, count_f); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (valid_f !== 1'b0 || empty_f !== 1'b1) begin errors++; $display("FAIL fwft_pop got valid=%b empty=%b expected 0 1", valid_f, empty_f); end
        tick();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (full_r !== 1'b1) begin errors++; $display("FAIL simul_prefull got %b expected 1", full_r); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (count_r !== 5'd15 || full_r !== 1'b0) begin errors++; $display("FAIL simul_full_count got %0d/%b expected 15/0", count_r, full_r); end
        checks++; if (dout_r !== 8'h10 || valid_r !== 1'b1) begin errors++; $display("FAIL simul_full_pop got %h/%b expected 10/1", dout_r, valid_r); end
        checks++; if (dout_f !== 8'h11) begin errors++; $display("FAIL simul_full_head got %h expected 11", dout_f); end
        for (int i = 1; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (dout_r !== 8'(8'h10 + i)) begin errors++; $display("FAIL simul_drain got %h expected %h", dout_r, 8'(8'h10 + i)); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (empty_r !== 1'b1 || valid_r !== 1'b0) begin errors++; $display("FAIL simul_drained got empty=%b valid=%b expected 1 0", empty_r, valid_r); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (count_r !== 5'd1 || valid_r !== 1'b0) begin errors++; $display("FAIL simul_empty got count=%0d valid=%b expected 1 0", count_r, valid_r); end
        checks++; if (dout_f !== 8'h77 || valid_f !== 1'b1) begin errors++; $display("FAIL simul_empty_fwft got %h/%b expected 77/1", dout_f, valid_f); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (dout_r !== 8'h77 || empty_r !== 1'b1) begin errors++; $display("FAIL simul_empty_read got %h/%b expected 77/1", dout_r, empty_r); end
        tick();
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h40 + i);
            tick();
        end
        data_in = 8'h99;
        tick();
        wr_en = 1'b0;
        checks++; if (count_r !== 5'd16 || full_r !== 1'b1) begin errors++; $display("FAIL err_ovf_count got %0d/%b expected 16/1", count_r, full_r); end
`ifdef SFIFO_ERR_EN
        checks++; if (ovf_r !== 1'b1 || ovf_f !== 1'b1) begin errors++; $display("FAIL err_ovf_set got %b/%b expected 1/1", ovf_r, ovf_f); end
        tick();
        checks++; if (ovf_r !== 1'b1) begin errors++; $display("FAIL err_ovf_sticky got %b expected 1", ovf_r); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL err_ovf_clr got %b expected 0", ovf_r); end
`else
        checks++; if (ovf_r !== 1'b0 || ovf_f !== 1'b0) begin errors++; $display("FAIL err_ovf_off got %b/%b expected 0/0", ovf_r, ovf_f); end
`endif
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (dout_r !== 8'(8'h40 + i)) begin errors++; $display("FAIL err_contents got %h expected %h", dout_r, 8'(8'h40 + i)); end
        end
        tick();
        rd_en = 1'b0;
        checks++; if (count_r !== 5'd0 || empty_r !== 1'b1 || valid_r !== 1'b0) begin errors++; $display("FAIL err_unf_state got count=%0d empty=%b valid=%b", count_r, empty_r, valid_r); end
`ifdef SFIFO_ERR_EN
        checks++; if (unf_r !== 1'b1 || unf_f !== 1'b1) begin errors++; $display("FAIL err_unf_set got %b/%b expected 1/1", unf_r, unf_f); end
        rd_en = 1'b1; err_clr = 1'b1;
        tick();
        rd_en = 1'b0; err_clr = 1'b0;
        checks++; if (unf_r !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b expected 1", unf_r); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (unf_r !== 1'b0) begin errors++; $display("FAIL err_unf_clr got %b expected 0", unf_r); end
`else
        checks++; if (unf_r !== 1'b0 || unf_f !== 1'b0) begin errors++; $display("FAIL err_unf_off got %b/%b expected 0/0", unf_r, unf_f); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        logic [7:0] exp_dout;
        logic       exp_valid;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h50 + i);
            tick();
        end
        rd_en = 1'b1; data_in = 8'h59;
        tick();
        checks++; if (count_r !== 5'd9 || valid_r !== 1'b1) begin errors++; $display("FAIL rst_pre got count=%0d valid=%b expected 9 1", count_r, valid_r); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count_r !== 5'd0 || count_f !== 5'd0) begin errors++; $display("FAIL rst_mid_count got %0d/%0d expected 0/0", count_r, count_f); end
        checks++; if (empty_r !== 1'b1 || empty_f !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b/%b expected 1/1", empty_r, empty_f); end
        checks++; if (valid_r !== 1'b0 || valid_f !== 1'b0 || dout_r !== 8'h00) begin errors++; $display("FAIL rst_mid_out got valid=%b/%b dout=%h", valid_r, valid_f, dout_r); end
        wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_dout = 8'h00;
        for (int i = 0; i < 40; i++) begin
            logic       w, r, wa, ra;
            logic [7:0] d;
            w  = (i < 26) && (i % 5 != 4);
            r  = (i % 6 == 5) || (i >= 26);
            d  = 8'(i * 7 + 3);
            wa = w && (q.size() < 16);
            ra = r && (q.size() > 0);
            checks++; if (valid_f !== (q.size() > 0)) begin errors++; $display("FAIL model_fwft_valid op %0d got %b", i, valid_f); end
            if (q.size() > 0) begin
                checks++; if (dout_f !== q[0]) begin errors++; $display("FAIL model_fwft_data op %0d got %h expected %h", i, dout_f, q[0]); end
            end
            wr_en = w; rd_en = r; data_in = d;
            tick();
            if (ra) exp_dout = q.pop_front();
            exp_valid = ra;
            if (wa) q.push_back(d);
            checks++; if (count_r !== 5'(q.size()) || count_f !== 5'(q.size())) begin errors++; $display("FAIL model_count op %0d got %0d/%0d expected %0d", i, count_r, count_f, q.size()); end
            checks++; if (full_r !== (q.size() == 16) || empty_r !== (q.size() == 0)) begin errors++; $display("FAIL model_flags op %0d got full=%b empty=%b", i, full_r, empty_r); end
            checks++; if (af_r !== (q.size() >= 14) || ae_r !== (q.size() <= 2)) begin errors++; $display("FAIL model_thresh op %0d got af=%b ae=%b", i, af_r, ae_r); end
            checks++; if (valid_r !== exp_valid || dout_r !== exp_dout) begin errors++; $display("FAIL model_reg op %0d got %h/%b expected %h/%b", i, dout_r, valid_r, exp_dout, exp_valid); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_reg_read();
        test_fwft();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
